// File: rtl/apbsubsys_irq_pkg.sv
// Shared constants and helpers for the APB interrupt controller.
package apbsubsys_irq_pkg;

    localparam int IRQ_ID_W = 6;

    localparam logic [11:0] ADDR_RAW    = 12'h000;
    localparam logic [11:0] ADDR_MASK   = 12'h004;
    localparam logic [11:0] ADDR_MODE   = 12'h008;
    localparam logic [11:0] ADDR_PEND   = 12'h00C;
    localparam logic [11:0] ADDR_STATUS = 12'h010;
    localparam logic [11:0] ADDR_ID     = 12'h014;

    typedef enum logic [2:0] {
        REG_RAW,
        REG_MASK,
        REG_MODE,
        REG_PEND,
        REG_STATUS,
        REG_ID,
        REG_NONE
    } reg_sel_e;

    // Lowest set bit index plus one; zero when nothing is set.
    function automatic logic [IRQ_ID_W-1:0] prio_id(input logic [31:0] vec);
        prio_id = '0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                prio_id = IRQ_ID_W'(i + 1);
            end
        end
    endfunction

endpackage

// File: rtl/apbsubsys_irq_ctrl_if.sv
// APB bus bundle between a master and the interrupt controller.
interface apbsubsys_irq_ctrl_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apbsubsys_irq_ctrl_sync.sv
// Multi-flop synchroniser bringing raw asynchronous requests into the PCLK domain.
module irq_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] stage_d [SYNC_STAGES];

    // Each stage takes the value of the stage before it; stage 0 samples the raw input.
    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Shift register with synchronous clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            if (!rst_n) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/apbsubsys_irq_ctrl.sv
// APB interrupt controller: synchronised sources, per-bit edge/level pending,
// masking, and a registered priority-encoded interrupt to the CPU.
module apbsubsys_irq_ctrl
    import apbsubsys_irq_pkg::*;
#(
    parameter int NUM_SRC     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apbsubsys_irq_ctrl_if.slave apb,
    input  logic [NUM_SRC-1:0]  int_src,
    output logic                irq_out,
    output logic [IRQ_ID_W-1:0] irq_id
);

    localparam logic [31:0] SRC_MASK  = (NUM_SRC >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << NUM_SRC) - 32'd1);
    // Edges are ignored until the synchroniser and sync_dly hold real post-reset samples,
    // so a source held high through reset does not look like a fresh rise.
    localparam logic [2:0]  WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [NUM_SRC-1:0]  sync;
    logic [31:0]         sync_w;
    logic [31:0]         sync_dly_q, sync_dly_d;
    logic [31:0]         mask_q, mask_d;
    logic [31:0]         mode_q, mode_d;
    logic [31:0]         pend_q, pend_d;
    logic                irq_out_q, irq_out_d;
    logic [IRQ_ID_W-1:0] irq_id_q, irq_id_d;
    logic [2:0]          warm_q, warm_d;
    logic [31:0]         status;
    logic [31:0]         rise;
    logic [31:0]         w1c;
    logic [31:0]         rd_data;
    logic                access;
    logic                wr_en;
    reg_sel_e            sel;
    logic                unused_addr_bits;

    irq_sync #(
        .WIDTH       (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .d     (int_src),
        .q     (sync)
    );

    assign unused_addr_bits = ^apb.PADDR[1:0];
    assign apb.PREADY       = 1'b1;
    assign status           = pend_q & mask_q;
    assign irq_out          = irq_out_q;
    assign irq_id           = irq_id_q;

    // Address decode, combinational read mux and error response.
    always_comb begin
        sync_w              = '0;
        sync_w[NUM_SRC-1:0] = sync;
        case ({apb.PADDR[11:2], 2'b00})
            ADDR_RAW:    sel = REG_RAW;
            ADDR_MASK:   sel = REG_MASK;
            ADDR_MODE:   sel = REG_MODE;
            ADDR_PEND:   sel = REG_PEND;
            ADDR_STATUS: sel = REG_STATUS;
            ADDR_ID:     sel = REG_ID;
            default:     sel = REG_NONE;
        endcase
        case (sel)
            REG_RAW:    rd_data = sync_w;
            REG_MASK:   rd_data = mask_q;
            REG_MODE:   rd_data = mode_q;
            REG_PEND:   rd_data = pend_q;
            REG_STATUS: rd_data = status;
            REG_ID:     rd_data = 32'(irq_id_q);
            default:    rd_data = '0;
        endcase
        access      = apb.PSEL & apb.PENABLE;
        wr_en       = access & apb.PWRITE & (sel != REG_NONE);
        apb.PSLVERR = access & (sel == REG_NONE);
        apb.PRDATA  = apb.PSEL ? rd_data : '0;
    end

    // Next-state for configuration, pending bits and the registered CPU outputs.
    always_comb begin
        mask_d     = mask_q;
        mode_d     = mode_q;
        w1c        = '0;
        sync_dly_d = sync_w;
        warm_d     = (warm_q == WARM_DONE) ? warm_q : warm_q + 3'd1;
        rise       = '0;
        if (wr_en && sel == REG_MASK) begin
            mask_d = apb.PWDATA & SRC_MASK;
        end
        if (wr_en && sel == REG_MODE) begin
            mode_d = apb.PWDATA & SRC_MASK;
        end
        if (wr_en && sel == REG_PEND) begin
            w1c = apb.PWDATA & SRC_MASK;
        end
        if (warm_q == WARM_DONE) begin
            rise = sync_w & ~sync_dly_q;
        end
        pend_d    = ((mode_q & ((pend_q & ~w1c) | rise)) | (~mode_q & sync_w)) & SRC_MASK;
        irq_out_d = |status;
        irq_id_d  = prio_id(status);
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            sync_dly_q <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            pend_q     <= '0;
            irq_out_q  <= 1'b0;
            irq_id_q   <= '0;
            warm_q     <= '0;
        end else begin
            sync_dly_q <= sync_dly_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            irq_out_q  <= irq_out_d;
            irq_id_q   <= irq_id_d;
            warm_q     <= warm_d;
        end
    end

endmodule

// File: tb/tb_apbsubsys_irq_ctrl.sv
// Directed self-checking bench for apbsubsys_irq_ctrl: a 32-source build with
// two sync stages and a 12-source build with three sync stages.
module tb_apbsubsys_irq_ctrl;
    import apbsubsys_irq_pkg::*;

    logic        PCLK;
    logic        PRESETn;
    logic        psel_a, psel_b, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] int_src;
    logic [11:0] int_src12;
    logic        irq_out, irq_out12;
    logic [5:0]  irq_id, irq_id12;
    logic [31:0] rd;
    logic        err;
    int          errors = 0;
    int          checks = 0;

    apbsubsys_irq_ctrl_if bus();
    apbsubsys_irq_ctrl_if bus12();

    assign bus.PSEL      = psel_a;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PADDR     = paddr;
    assign bus.PWDATA    = pwdata;
    assign bus12.PSEL    = psel_b;
    assign bus12.PENABLE = penable;
    assign bus12.PWRITE  = pwrite;
    assign bus12.PADDR   = paddr;
    assign bus12.PWDATA  = pwdata;

    apbsubsys_irq_ctrl #(.NUM_SRC(32), .SYNC_STAGES(2)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus.slave),
        .int_src (int_src),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    apbsubsys_irq_ctrl #(.NUM_SRC(12), .SYNC_STAGES(3)) dut12 (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus12.slave),
        .int_src (int_src12),
        .irq_out (irq_out12),
        .irq_id  (irq_id12)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input bit b12, input logic [31:0] v);
        if (b12) int_src12 = v[11:0];
        else     int_src   = v;
    endtask

    task automatic apbWrite(input bit b12, input logic [11:0] a, input logic [31:0] d, output logic e);
        @(posedge PCLK); #1;
        psel_a = !b12; psel_b = b12; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #1;
        e = b12 ? bus12.PSLVERR : bus.PSLVERR;
        @(posedge PCLK); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apbRead(input bit b12, input logic [11:0] a, output logic [31:0] d, output logic e);
        @(posedge PCLK); #1;
        psel_a = !b12; psel_b = b12; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge PCLK); #1;
        penable = 1'b1;
        #1;
        d = b12 ? bus12.PRDATA : bus.PRDATA;
        e = b12 ? bus12.PSLVERR : bus.PSLVERR;
        @(posedge PCLK); #1;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    endtask

    // Setup-phase-only look at a register; PRDATA is combinational so no clock edge is needed.
    task automatic peek(input bit b12, input logic [11:0] a, output logic [31:0] d);
        psel_a = !b12; psel_b = b12; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1;
        d = b12 ? bus12.PRDATA : bus.PRDATA;
        psel_a = 1'b0; psel_b = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        int_src = '0; int_src12 = '0;
        step(3);

        // Reset state
        checkOutput("rst_irq_out", 32'(irq_out), 32'd0);
        checkOutput("rst_irq_id", 32'(irq_id), 32'd0);
        peek(0, ADDR_MASK, rd); checkOutput("rst_mask", rd, 32'd0);
        peek(0, ADDR_PEND, rd); checkOutput("rst_pend", rd, 32'd0);
        checkOutput("pready", 32'(bus.PREADY), 32'd1);
        PRESETn = 1'b1;

        // Edge capture on source 0
        apbWrite(0, ADDR_MODE, 32'h1, err);
        apbWrite(0, ADDR_MASK, 32'h1, err);
        applyStimulus(0, 32'h1);
        step(2);
        peek(0, ADDR_PEND, rd); checkOutput("edge_pend_early", rd, 32'd0);
        step(1);
        peek(0, ADDR_PEND, rd); checkOutput("edge_pend_set", rd, 32'h1);
        checkOutput("edge_irq_not_yet", 32'(irq_out), 32'd0);
        applyStimulus(0, 32'h0);
        step(1);
        checkOutput("edge_irq_out", 32'(irq_out), 32'd1);
        checkOutput("edge_irq_id", 32'(irq_id), 32'd1);
        step(3);
        peek(0, ADDR_PEND, rd); checkOutput("edge_pend_held", rd, 32'h1);
        apbWrite(0, ADDR_PEND, 32'h1, err);
        peek(0, ADDR_PEND, rd); checkOutput("edge_pend_w1c", rd, 32'd0);
        checkOutput("edge_irq_lag", 32'(irq_out), 32'd1);
        step(1);
        checkOutput("edge_irq_clear", 32'(irq_out), 32'd0);
        checkOutput("edge_id_clear", 32'(irq_id), 32'd0);

        // Level follow on source 8
        apbWrite(0, ADDR_MODE, 32'h0, err);
        apbWrite(0, ADDR_MASK, 32'h100, err);
        applyStimulus(0, 32'h100);
        step(3);
        checkOutput("lvl_irq_not_yet", 32'(irq_out), 32'd0);
        step(1);
        checkOutput("lvl_irq_out", 32'(irq_out), 32'd1);
        checkOutput("lvl_irq_id", 32'(irq_id), 32'd9);
        apbWrite(0, ADDR_PEND, 32'h100, err);
        peek(0, ADDR_PEND, rd); checkOutput("lvl_w1c_ignored", rd, 32'h100);
        applyStimulus(0, 32'h0);
        step(3);
        checkOutput("lvl_irq_hold", 32'(irq_out), 32'd1);
        step(1);
        checkOutput("lvl_irq_drop", 32'(irq_out), 32'd0);

        // Priority between sources 3 and 5
        apbWrite(0, ADDR_MASK, 32'hFFFF_FFFF, err);
        applyStimulus(0, 32'h28);
        step(4);
        checkOutput("prio_id_3_5", 32'(irq_id), 32'd4);
        apbRead(0, ADDR_STATUS, rd, err); checkOutput("prio_status", rd, 32'h28);
        apbRead(0, ADDR_ID, rd, err); checkOutput("prio_id_reg", rd, 32'd4);
        applyStimulus(0, 32'h20);
        step(4);
        checkOutput("prio_id_5", 32'(irq_id), 32'd6);
        applyStimulus(0, 32'h0);
        step(4);
        checkOutput("prio_id_none", 32'(irq_id), 32'd0);
        checkOutput("prio_irq_none", 32'(irq_out), 32'd0);

        // W1C racing a new rise on edge-mode bit 2
        apbWrite(0, ADDR_MODE, 32'h4, err);
        applyStimulus(0, 32'h4);
        step(3);
        applyStimulus(0, 32'h0);
        step(4);
        peek(0, ADDR_PEND, rd); checkOutput("race_pre", rd, 32'h4);
        applyStimulus(0, 32'h4);
        apbWrite(0, ADDR_PEND, 32'h4, err);
        peek(0, ADDR_PEND, rd); checkOutput("race_set_wins", rd, 32'h4);
        step(4);
        apbWrite(0, ADDR_PEND, 32'h4, err);
        peek(0, ADDR_PEND, rd); checkOutput("race_plain_w1c", rd, 32'd0);

        // Error responses and read-only writes
        apbRead(0, 12'h018, rd, err);
        checkOutput("err_slverr", 32'(err), 32'd1);
        checkOutput("err_prdata", rd, 32'd0);
        apbWrite(0, ADDR_RAW, 32'hFFFF_FFFF, err);
        checkOutput("ro_slverr", 32'(err), 32'd0);
        apbRead(0, ADDR_RAW, rd, err);
        checkOutput("ro_raw", rd, 32'h4);
        apbWrite(0, 12'h01C, 32'h0, err);
        checkOutput("err_wr_slverr", 32'(err), 32'd1);
        apbRead(0, ADDR_MASK, rd, err);
        checkOutput("err_wr_nochange", rd, 32'hFFFF_FFFF);

        // 12-source build: width clipping
        apbWrite(1, ADDR_MASK, 32'hFFFF_FFFF, err);
        apbRead(1, ADDR_MASK, rd, err); checkOutput("n12_mask", rd, 32'h0000_0FFF);
        apbWrite(1, ADDR_MODE, 32'hFFFF_FFFF, err);
        apbRead(1, ADDR_MODE, rd, err); checkOutput("n12_mode", rd, 32'h0000_0FFF);

        // 12-source build: reset mid-pulse with the source held high
        applyStimulus(1, 32'h1);
        step(5);
        checkOutput("n12_irq_before_rst", 32'(irq_out12), 32'd1);
        PRESETn = 1'b0;
        step(2);
        checkOutput("n12_rst_irq", 32'(irq_out12), 32'd0);
        checkOutput("n12_rst_id", 32'(irq_id12), 32'd0);
        peek(1, ADDR_MASK, rd); checkOutput("n12_rst_mask", rd, 32'd0);
        peek(1, ADDR_PEND, rd); checkOutput("n12_rst_pend", rd, 32'd0);
        PRESETn = 1'b1;
        apbWrite(1, ADDR_MODE, 32'h1, err);
        apbWrite(1, ADDR_MASK, 32'h1, err);
        step(6);
        peek(1, ADDR_PEND, rd); checkOutput("n12_no_edge", rd, 32'd0);
        checkOutput("n12_no_irq", 32'(irq_out12), 32'd0);
        applyStimulus(1, 32'h0);
        step(5);
        applyStimulus(1, 32'h1);
        step(3);
        peek(1, ADDR_PEND, rd); checkOutput("n12_pend_early", rd, 32'd0);
        step(1);
        peek(1, ADDR_PEND, rd); checkOutput("n12_rearm_pend", rd, 32'h1);
        step(1);
        checkOutput("n12_rearm_irq", 32'(irq_out12), 32'd1);
        checkOutput("n12_rearm_id", 32'(irq_id12), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apbsubsys_irq_ctrl.md
APBSUBSYS_IRQ_CTRL -- requirements
Module: apbsubsys_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 32, number of interrupt sources; legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth on each source; legal range 2..3.
REQ-003 PCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 PRESETn  input  1  reset; synchronous, active-low.
REQ-005 PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-006 PADDR  input  12  byte address; bits [1:0] ignored.
REQ-007 PWDATA  input  32  APB write data.
REQ-008 PRDATA  output  32  APB read data.
REQ-009 PREADY  output  1  tied to 1; zero wait states.
REQ-010 PSLVERR  output  1  error on unmapped access.
REQ-011 int_src  input  NUM_SRC  raw asynchronous interrupt requests, active-high.
REQ-012 irq_out  output  1  aggregated registered interrupt to the CPU.
REQ-013 irq_id  output  6  registered highest-priority active source ID plus 1; 0 = none.

Function
REQ-014 SHALL pass each int_src bit through SYNC_STAGES flops; the last stage output is "sync".
REQ-015 SHALL register sync once more ("sync_d"); rise = sync & ~sync_d.
REQ-016 Register map, 32-bit words; bits at index >= NUM_SRC read 0 and ignore writes:
  0x00 RAW (RO) = sync; 0x04 MASK (RW, 1 = enabled); 0x08 MODE (RW, 1 = edge, 0 = level);
  0x0C PEND (RO read, W1C write); 0x10 STATUS (RO) = PEND & MASK; 0x14 ID (RO) = irq_id zero-extended.
REQ-017 Level-mode bit: PEND = sync; W1C has no effect.
REQ-018 Edge-mode bit: PEND sets on rise and clears on a W1C write of 1; set and clear in the same cycle leaves PEND = 1.
REQ-019 Changing MODE from edge to level SHALL make PEND follow sync on the next cycle; changing level to edge SHALL keep the current PEND value.
REQ-020 irq_out SHALL be registered as the OR of STATUS, one cycle after STATUS changes.
REQ-021 irq_id SHALL be registered as lowest set index of STATUS plus 1, same cycle as irq_out; index 0 is highest priority.
REQ-022 Latency: int_src rising edge to PEND set = SYNC_STAGES+1 cycles; to irq_out = SYNC_STAGES+2 cycles.
REQ-023 Writes SHALL commit in the access phase (PSEL & PENABLE & PWRITE).
REQ-024 PRDATA SHALL be combinational from the register selected by PADDR while PSEL=1; PRDATA = 0 otherwise.
REQ-025 Access to any address > 0x14 SHALL assert PSLVERR in the access phase; PRDATA = 0 and no state changes.
REQ-026 Writes to RO registers SHALL be ignored with PSLVERR = 0.
REQ-027 A pulse shorter than one PCLK period is not guaranteed to be captured; a pulse of at least 2 PCLK periods SHALL be captured.

Reset
REQ-028 While PRESETn=0 at a PCLK edge, SHALL clear all synchroniser flops, sync_d, MASK, MODE, PEND, irq_out and irq_id to 0.
REQ-029 Reset asserted mid-operation SHALL discard pending edges; a source held high through reset SHALL NOT produce an edge-mode PEND after release until it falls and rises again.

Structure
REQ-030 SHALL place the register offset constants and the IRQ_ID_W = 6 constant in shared package apbsubsys_irq_pkg.
REQ-031 SHALL implement the synchroniser as a separate sub-module, irq_sync, parametrised by width and SYNC_STAGES.
REQ-032 SHALL implement the priority encoder as a function or loop; no separate module.

Verification
REQ-033 Edge capture: MODE=0x1, MASK=0x1, 3-cycle pulse on int_src[0] -> PEND=0x1 at cycle SYNC_STAGES+1, irq_out=1 and irq_id=1 one cycle later; write PEND=0x1 -> irq_out=0 two cycles later.
REQ-034 Level follow: MODE=0, MASK=0x100, hold int_src[8] high -> irq_id=9; W1C PEND has no effect; drop int_src[8] -> irq_out=0 after SYNC_STAGES+2 cycles.
REQ-035 Priority: MASK=0xFFFFFFFF, sources 5 and 3 active -> irq_id=4; clear source 3 -> irq_id=6.
REQ-036 Race: edge-mode W1C of bit 2 in the same cycle a new rise on bit 2 arrives -> PEND[2] stays 1.
REQ-037 Errors: read 0x18 -> PSLVERR=1 and PRDATA=0; write 0xFFFFFFFF to RAW -> PSLVERR=0 and RAW unchanged.
REQ-038 NUM_SRC=12 build: write MASK=0xFFFFFFFF -> MASK reads 0x00000FFF; assert PRESETn=0 mid-pulse -> all outputs read 0 and no edge is reported after release.
